pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_mc_timer.sv | 37 +++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared stall encodings, states and defaults          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int c_ADDR_W_DEFAULT = 32;
  localparam int c_STALL_W        = 6;

  localparam int c_STALL_PC     = 0;
  localparam int c_STALL_IF_ID  = 1;
  localparam int c_STALL_ID_EX  = 2;
  localparam int c_STALL_EX_MEM = 3;
  localparam int c_STALL_MEM_WB = 4;
  localparam int c_STALL_RSVD   = 5;

  localparam logic [c_STALL_W-1:0] c_STALL_NONE = 6'b000000;
  localparam logic [c_STALL_W-1:0] c_STALL_ID   = c_STALL_W'(1 << c_STALL_PC)
                                                | c_STALL_W'(1 << c_STALL_IF_ID)
                                                | c_STALL_W'(1 << c_STALL_ID_EX);
  localparam logic [c_STALL_W-1:0] c_STALL_EX   = c_STALL_ID
                                                | c_STALL_W'(1 << c_STALL_EX_MEM);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MC_BUSY = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_mc_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_timer : multi-cycle op down-counter with load/decrement/cancel    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_cancel,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_load_val;

  // A zero-length op still occupies one cycle.
  assign w_load_val = (i_load_val == '0) ? CNT_W'(1) : i_load_val;

  always_ff @(posedge clk) begin
    if (rst || i_cancel) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl : pipeline stall/flush controller with multi-cycle EX ops  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_id,
  input  logic                 ex_mc_start,
  input  logic [CNT_W-1:0]     ex_mc_cycles,
  input  logic                 ex_mc_cancel,
  input  logic                 flush_req,
  input  logic [ADDR_W-1:0]    flush_pc,
  output logic [c_STALL_W-1:0] stall,
  output logic                 flush,
  output logic [ADDR_W-1:0]    new_pc,
  output logic                 ex_mc_busy,
  output logic                 ex_mc_done
);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_W-1:0]     r_new_pc;
  logic [c_STALL_W-1:0]  w_stall;
  logic                  w_tmr_load;
  logic                  w_tmr_dec;
  logic                  w_tmr_cancel;
  logic                  w_tmr_last;

  mc_timer #(
    .CNT_W (CNT_W)
  ) u_mc_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (ex_mc_cycles),
    .i_dec      (w_tmr_dec),
    .i_cancel   (w_tmr_cancel),
    .o_last     (w_tmr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_new_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (flush_req) begin
        r_new_pc <= flush_pc;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = c_STALL_NONE;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    w_tmr_cancel = 1'b0;

    // A redirect outranks everything, including a restart while already flushing.
    if (flush_req) begin
      w_next_state = S_FLUSH;
      w_tmr_cancel = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_mc_start) begin
            w_stall      = c_STALL_EX;
            w_tmr_load   = 1'b1;
            w_next_state = S_MC_BUSY;
          end else if (stallreq_id) begin
            w_stall = c_STALL_ID;
          end
        end
        S_MC_BUSY: begin
          if (ex_mc_cancel) begin
            w_tmr_cancel = 1'b1;
            w_next_state = S_IDLE;
          end else if (w_tmr_last) begin
            w_tmr_dec    = 1'b1;
            w_next_state = S_IDLE;
            if (stallreq_id) begin
              w_stall = c_STALL_ID;
            end
          end else begin
            w_tmr_dec = 1'b1;
            w_stall   = c_STALL_EX;
          end
        end
        S_FLUSH: begin
          w_next_state = S_IDLE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall               = rst ? c_STALL_NONE : w_stall;
    stall[c_STALL_RSVD] = 1'b0;
  end

  assign flush      = (r_state == S_FLUSH);
  assign new_pc     = r_new_pc;
  assign ex_mc_busy = (r_state == S_MC_BUSY) && !w_tmr_last;
  assign ex_mc_done = (r_state == S_MC_BUSY) && w_tmr_last;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_ctrl : directed + randomized bench against a schedule model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_ID   = 6'b000111;
  localparam logic [5:0] E_EX   = 6'b001111;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        ex_mc_cancel;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_busy;
  logic        ex_mc_done;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .ex_mc_cancel (ex_mc_cancel),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_busy   (ex_mc_busy),
    .ex_mc_done   (ex_mc_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: absolute cycle numbers at which the op completes / the flush pulse shows.
  int          cyc;
  int          done_at;
  int          flush_at;
  logic [31:0] m_pc;

  logic [5:0]  last_stall;
  logic        last_done;
  logic        last_busy;
  logic        last_flush;
  logic [31:0] last_pc;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic sreq, input logic st, input logic [5:0] n,
                      input logic cn, input logic fr, input logic [31:0] fp);
    logic       e_flush;
    logic       e_done;
    logic       e_busy;
    logic       in_op;
    logic [5:0] e_stall;
    rst = r; stallreq_id = sreq; ex_mc_start = st; ex_mc_cycles = n;
    ex_mc_cancel = cn; flush_req = fr; flush_pc = fp;
    @(negedge clk);
    e_flush = (flush_at == cyc);
    e_done  = (done_at == cyc);
    e_busy  = (done_at > cyc);
    in_op   = (done_at >= cyc);
    if (r || fr || e_flush)  e_stall = E_NONE;
    else if (in_op)          e_stall = cn ? E_NONE : (e_done ? (sreq ? E_ID : E_NONE) : E_EX);
    else                     e_stall = st ? E_EX : (sreq ? E_ID : E_NONE);
    check_value("stall", stall, e_stall);
    check_value("flush", flush, e_flush);
    check_value("busy",  ex_mc_busy, e_busy);
    check_value("done",  ex_mc_done, e_done);
    if (e_flush) check_value("new_pc", new_pc, m_pc);
    last_stall = stall; last_done = ex_mc_done; last_busy = ex_mc_busy;
    last_flush = flush; last_pc = new_pc;
    @(posedge clk); #1;
    if (r) begin
      done_at = -1; flush_at = -1; m_pc = '0;
    end else if (fr) begin
      flush_at = cyc + 1; m_pc = fp; done_at = -1;
    end else if (e_flush) begin
      done_at = -1;
    end else if (in_op) begin
      if (cn || e_done) done_at = -1;
    end else if (st) begin
      done_at = cyc + ((n == 6'd0) ? 1 : int'(n));
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int ex_cnt;
    int done_k;
    int dones;
    int k;
    rst = 1'b1; stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = '0;
    ex_mc_cancel = 1'b0; flush_req = 1'b0; flush_pc = '0;
    cyc = 0; done_at = -1; flush_at = -1; m_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_value("rst_stall",  stall, E_NONE);
    check_value("rst_flush",  flush, 1'b0);
    check_value("rst_new_pc", new_pc, 32'h0);
    check_value("rst_busy",   ex_mc_busy, 1'b0);
    check_value("rst_done",   ex_mc_done, 1'b0);
    @(posedge clk); #1;

    // ID hazard for a single cycle
    step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    check_value("sreq_stall", last_stall, E_ID);
    idle();
    check_value("sreq_release", last_stall, E_NONE);

    // N=4 op: four stall cycles, done four cycles after start
    step(1'b0, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 32'h0);
    ex_cnt = (last_stall == E_EX) ? 1 : 0;
    done_k = -1;
    for (int i = 1; i <= 5; i++) begin
      idle();
      if (last_stall == E_EX) ex_cnt++;
      if (last_done) done_k = i;
    end
    check_value("n4_stall_cycles", ex_cnt, 4);
    check_value("n4_done_offset", done_k, 4);

    // Cancel at T+2
    step(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 32'h0);
    idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    check_value("cancel_stall", last_stall, E_NONE);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (last_done) dones++;
    end
    check_value("cancel_no_done", dones, 0);

    // Flush during a multi-cycle op
    step(1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 32'h0);
    idle();
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_0040);
    check_value("flush_req_stall", last_stall, E_NONE);
    idle();
    check_value("flush_pulse", last_flush, 1'b1);
    check_value("flush_pc", last_pc, 32'h0000_0040);
    check_value("flush_busy", last_busy, 1'b0);
    idle();
    check_value("flush_over", last_flush, 1'b0);

    // Back-to-back redirects restart the flush
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1, 32'h0000_0200);
    idle();
    check_value("reflush_pc", last_pc, 32'h0000_0200);
    idle();

    // N=0 behaves as N=1
    step(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'h0);
    check_value("n0_stall", last_stall, E_EX);
    idle();
    check_value("n0_done", last_done, 1'b1);

    // Reset mid-op and mid-flush
    step(1'b0, 1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 32'h0);
    idle();
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    idle();
    check_value("rst_abort_busy", last_busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h0000_0080);
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    idle();
    check_value("rst_abort_flush", last_flush, 1'b0);

    // Maximum length: 63 stall cycles, no wrap
    step(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 32'h0);
    ex_cnt = (last_stall == E_EX) ? 1 : 0;
    k = 0;
    while (!last_done && k < 100) begin
      idle();
      k++;
      if (last_stall == E_EX) ex_cnt++;
    end
    check_value("nmax_stall_cycles", ex_cnt, 63);
    check_value("nmax_done_offset", k, 63);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           6'($urandom_range(0, 12)),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 19) == 0),
           $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
